// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq: iterative packed-BCD to binary converter, one digit per clock, MSD first.
module bcd_to_bin_seq #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic                  busy,
  output logic                  done,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  err
);
  localparam int CW = $clog2(DIGITS + 1);
  typedef enum logic {IDLE, CONV} state_t;
  state_t              state_q, state_d;
  logic [4*DIGITS-1:0] sr_q, sr_d;
  logic [BIN_W-1:0]    acc_q, acc_d, acc_next, bin_q, bin_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                bad_q, bad_d, busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic [3:0]          dig;
  logic                bad_now;
  always_comb begin
    dig      = sr_q[4*DIGITS-1 -: 4];
    acc_next = (acc_q << 3) + (acc_q << 1) + BIN_W'(dig);
    bad_now  = bad_q | (dig > 4'd9);
    state_d  = state_q;
    sr_d     = sr_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    bad_d    = bad_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    bin_d    = bin_q;
    err_d    = err_q;
    if (state_q == IDLE) begin
      if (start) begin
        state_d = CONV;
        sr_d    = bcd_in;
        acc_d   = '0;
        cnt_d   = CW'(DIGITS);
        bad_d   = 1'b0;
        busy_d  = 1'b1;
      end
    end else begin
      acc_d = acc_next;
      sr_d  = sr_q << 4;
      cnt_d = cnt_q - CW'(1);
      bad_d = bad_now;
      // last digit: publish result, a bad digit anywhere forces zero
      if (cnt_q == CW'(1)) begin
        state_d = IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        bin_d   = bad_now ? '0 : acc_next;
        err_d   = bad_now;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bad_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bin_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      bad_q   <= bad_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      bin_q   <= bin_d;
      err_q   <= err_d;
    end
  end
  assign busy    = busy_q;
  assign done    = done_q;
  assign bin_out = bin_q;
  assign err     = err_q;
endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// tb_bcd_to_bin_seq: directed checks of bcd_to_bin_seq at 4 digits and at 2 digits.
module tb_bcd_to_bin_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0, start2 = 1'b0;
  logic [15:0] bcd = '0;
  logic [7:0]  bcd2 = '0;
  logic        busy, done, err, busy2, done2, err2;
  logic [13:0] bin;
  logic [6:0]  bin2;
  int          n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  bcd_to_bin_seq #(.DIGITS(4), .BIN_W(14)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bcd_in(bcd),
    .busy(busy), .done(done), .bin_out(bin), .err(err));

  bcd_to_bin_seq #(.DIGITS(2), .BIN_W(7)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .bcd_in(bcd2),
    .busy(busy2), .done(done2), .bin_out(bin2), .err(err2));

  // pulse start for one edge; returns at the negedge right after the accepting edge
  task automatic kick(input logic [15:0] v);
    @(negedge clk);
    start = 1'b1;
    bcd   = v;
    @(negedge clk);
    start = 1'b0;
  endtask

  // counts negedges until done is seen, bounded at 20
  task automatic wait_done(input bit sel, output int lat);
    lat = 0;
    while (!(sel ? done2 : done) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, bin, err} !== 17'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b done=%b bin=%0d err=%b, want all 0", busy, done, bin, err);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    int lat;
    kick(16'h1999);
    n_checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_busy: busy=%b done=%b, want busy=1 done=0", busy, done);
    end
    wait_done(1'b0, lat);
    n_checks++;
    if (lat !== 4) begin
      n_fail++;
      $display("FAIL basic_latency: got %0d, want 4", lat);
    end
    n_checks++;
    if (bin !== 14'd1999 || err !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_result: bin=%0d err=%b busy=%b, want 1999 0 0", bin, err, busy);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    kick(16'h9999);
    wait_done(1'b0, lat);
    n_checks++;
    if (lat !== 4 || bin !== 14'd9999 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_first: lat=%0d bin=%0d err=%b, want 4 9999 0", lat, bin, err);
    end
    start = 1'b1;
    bcd   = 16'h0000;
    @(negedge clk);
    start = 1'b0;
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_accept: done=%b busy=%b, want 0 1", done, busy);
    end
    wait_done(1'b0, lat);
    n_checks++;
    if (lat !== 4 || bin !== 14'd0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second: lat=%0d bin=%0d err=%b, want 4 0 0", lat, bin, err);
    end
  endtask

  task automatic test_invalid;
    int lat;
    kick(16'h12A4);
    wait_done(1'b0, lat);
    n_checks++;
    if (lat !== 4 || bin !== 14'd0 || err !== 1'b1) begin
      n_fail++;
      $display("FAIL invalid_digit: lat=%0d bin=%0d err=%b, want 4 0 1", lat, bin, err);
    end
    kick(16'h2024);
    wait_done(1'b0, lat);
    n_checks++;
    if (lat !== 4 || bin !== 14'h07E8 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL after_invalid: lat=%0d bin=%0d err=%b, want 4 2024 0", lat, bin, err);
    end
  endtask

  task automatic test_start_while_busy;
    int dones = 0;
    kick(16'h0042);
    @(negedge clk);
    start = 1'b1;
    bcd   = 16'h0077;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done) dones++;
      @(negedge clk);
    end
    n_checks++;
    if (dones !== 1 || bin !== 14'd42 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_busy_start: dones=%0d bin=%0d busy=%b, want 1 42 0", dones, bin, busy);
    end
  endtask

  task automatic test_reset_mid;
    int dones = 0;
    int lat;
    kick(16'h2100);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0 || bin !== 14'd0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: busy=%b done=%b bin=%0d err=%b, want 0 0 0 0", busy, done, bin, err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (done) dones++;
      @(negedge clk);
    end
    n_checks++;
    if (dones !== 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_no_done: dones=%0d busy=%b, want 0 0", dones, busy);
    end
    kick(16'h2100);
    wait_done(1'b0, lat);
    n_checks++;
    if (lat !== 4 || bin !== 14'h0834 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_restart: lat=%0d bin=%0d err=%b, want 4 2100 0", lat, bin, err);
    end
  endtask

  task automatic test_two_digit;
    int lat;
    @(negedge clk);
    start2 = 1'b1;
    bcd2   = 8'h99;
    @(negedge clk);
    start2 = 1'b0;
    n_checks++;
    if (busy2 !== 1'b1) begin
      n_fail++;
      $display("FAIL two_digit_busy: busy=%b, want 1", busy2);
    end
    wait_done(1'b1, lat);
    n_checks++;
    if (lat !== 2 || bin2 !== 7'd99 || err2 !== 1'b0) begin
      n_fail++;
      $display("FAIL two_digit_99: lat=%0d bin=%0d err=%b, want 2 99 0", lat, bin2, err2);
    end
    @(negedge clk);
    start2 = 1'b1;
    bcd2   = 8'h00;
    @(negedge clk);
    start2 = 1'b0;
    wait_done(1'b1, lat);
    n_checks++;
    if (lat !== 2 || bin2 !== 7'd0 || err2 !== 1'b0) begin
      n_fail++;
      $display("FAIL two_digit_00: lat=%0d bin=%0d err=%b, want 2 0 0", lat, bin2, err2);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_back_to_back;
    test_invalid;
    test_start_while_busy;
    test_reset_mid;
    test_two_digit;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
